pattern_response_checker: RTL and testbench

- On-chip consumer for test-pattern/response streams produced by the pattern generation flow.
- Accepts one (pattern, observed response, expected response) beat per handshake and compares observed against expected.
- Counts mismatches, records the index of the first failing pattern, and compacts every beat into a MISR signature.
- Sits between the circuit-under-test output capture and the fault-report logic; it is the response-analysis end of the pattern interface.

---
 rtl/pattern_response_checker.sv | 132 +++++++++++++
 tb/tb_pattern_response_checker.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_response_checker.sv
// Response-analysis end of the pattern interface: compares observed against
// expected responses beat by beat, counts mismatches, remembers the first
// failing pattern index and compacts every beat into a MISR signature.
module pattern_response_checker #(
    parameter int              PIN_W    = 2,
    parameter int              POUT_W   = 1,
    parameter int              CNT_W    = 8,
    parameter int              SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SIG_SEED = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_pat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIN_W-1:0]  pat_in,
    input  logic [POUT_W-1:0] obs_in,
    input  logic [POUT_W-1:0] exp_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_valid,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [SIG_W-1:0]  signature
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType state;
    stateType nextState;

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] numPat;
    logic [CNT_W-1:0] lastIdx;
    logic [CNT_W-1:0] failCnt;
    logic             firstFailValid;
    logic [CNT_W-1:0] firstFailIdx;
    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] misrIn;
    logic [SIG_W-1:0] misrNext;
    logic             accept;
    logic             mismatch;
    logic             startRun;

    // Beats are only taken in RUN; start is only honoured once a run is not in progress
    assign accept   = in_valid && (state == RUN);
    assign mismatch = |(obs_in ^ exp_in);
    assign startRun = start && ((state == IDLE) || (state == DONE));
    assign lastIdx  = numPat - CNT_W'(1);

    // State register, cleared to IDLE by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: zero-length runs go straight to DONE, others end on the last accepted beat
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nextState = (num_pat != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (accept && (idx == lastIdx)) begin
                    nextState = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // MISR update: shift left, fold in the polynomial when the top bit falls out, xor in the beat
    always_comb begin
        misrIn = '0;
        misrIn[PIN_W+POUT_W-1:0] = {pat_in, obs_in};
        misrNext = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : '0) ^ misrIn;
    end

    // Run bookkeeping: re-seed on start, then count, record first failure and compact each beat
    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            numPat         <= '0;
            failCnt        <= '0;
            firstFailValid <= 1'b0;
            firstFailIdx   <= '0;
            sig            <= '0;
        end else if (startRun) begin
            idx            <= '0;
            numPat         <= num_pat;
            failCnt        <= '0;
            firstFailValid <= 1'b0;
            firstFailIdx   <= '0;
            sig            <= SIG_SEED;
        end else if (accept) begin
            if (mismatch) begin
                if (failCnt != '1) begin
                    failCnt <= failCnt + CNT_W'(1);
                end
                if (!firstFailValid) begin
                    firstFailValid <= 1'b1;
                    firstFailIdx   <= idx;
                end
            end
            sig <= misrNext;
            idx <= idx + CNT_W'(1);
        end
    end

    assign in_ready         = (state == RUN);
    assign busy             = (state == RUN);
    assign done             = (state == DONE);
    assign pass             = (state == DONE) && (failCnt == '0);
    assign fail_cnt         = failCnt;
    assign first_fail_valid = firstFailValid;
    assign first_fail_idx   = firstFailIdx;
    assign signature        = sig;

endmodule

// File: tb/tb_pattern_response_checker.sv
// Directed bench for pattern_response_checker: expected run results are
// pushed to a scoreboard when a run is launched and popped when done rises.
module tb_pattern_response_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  num_pat;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  pat_in;
    logic        obs_in;
    logic        exp_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  fail_cnt;
    logic        first_fail_valid;
    logic [7:0]  first_fail_idx;
    logic [15:0] signature;

    logic        start2;
    logic [1:0]  numPat2;
    logic        ready2;
    logic        busy2;
    logic        done2;
    logic        pass2;
    logic [1:0]  failCnt2;
    logic        ffValid2;
    logic [1:0]  ffIdx2;
    logic [15:0] sig2;

    typedef struct {
        logic        pass;
        logic [7:0]  failCnt;
        logic        ffValid;
        logic [7:0]  ffIdx;
        logic [15:0] sig;
    } expType;

    expType sb[$];

    logic [1:0] bPat[8];
    logic       bObs[8];
    logic       bExp[8];

    int errors = 0;
    int checks = 0;

    pattern_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .num_pat(num_pat),
        .in_valid(in_valid), .in_ready(in_ready),
        .pat_in(pat_in), .obs_in(obs_in), .exp_in(exp_in),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx),
        .signature(signature)
    );

    pattern_response_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .num_pat(numPat2),
        .in_valid(in_valid), .in_ready(ready2),
        .pat_in(pat_in), .obs_in(obs_in), .exp_in(exp_in),
        .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(failCnt2),
        .first_fail_valid(ffValid2), .first_fail_idx(ffIdx2),
        .signature(sig2)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a run never completes
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [1:0] p, input logic o);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ 16'h1021;
        r = r ^ {13'd0, p, o};
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setBeat(input int i, input logic [1:0] p, input logic o, input logic e);
        bPat[i] = p;
        bObs[i] = o;
        bExp[i] = e;
    endtask

    task automatic pushExpected(input int n, input int satMax);
        expType e;
        int fc;
        fc = 0;
        e.ffValid = 1'b0;
        e.ffIdx = 8'd0;
        e.sig = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (bObs[i] != bExp[i]) begin
                if (fc < satMax) fc++;
                if (!e.ffValid) begin
                    e.ffValid = 1'b1;
                    e.ffIdx = 8'(i);
                end
            end
            e.sig = misrStep(e.sig, bPat[i], bObs[i]);
        end
        e.failCnt = 8'(fc);
        e.pass = (fc == 0);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int n, input int gap);
        expType e;
        pushExpected(n, 255);
        start = 1'b1;
        num_pat = 8'(n);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busyAfterStart", busy, (n != 0));
        checkOutput("sigSeeded", signature, 16'hFFFF);
        checkOutput("failCntCleared", fail_cnt, 0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            pat_in = bPat[i];
            obs_in = bObs[i];
            exp_in = bExp[i];
            checkOutput("readyInRun", in_ready, 1);
            if (i == n - 1) checkOutput("doneBeforeLast", done, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("doneLatency", done, 1);
        checkOutput("readyInDone", in_ready, 0);
        e = sb.pop_front();
        checkOutput("pass", pass, e.pass);
        checkOutput("failCnt", fail_cnt, e.failCnt);
        checkOutput("firstFailValid", first_fail_valid, e.ffValid);
        checkOutput("firstFailIdx", first_fail_idx, e.ffIdx);
        checkOutput("signature", signature, e.sig);
    endtask

    // Directed sequence of runs
    initial begin
        expType e;
        rst = 1'b1;
        start = 1'b0;
        num_pat = 8'd0;
        start2 = 1'b0;
        numPat2 = 2'd0;
        in_valid = 1'b0;
        pat_in = 2'd0;
        obs_in = 1'b0;
        exp_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstPass", pass, 0);
        checkOutput("rstSig", signature, 0);
        checkOutput("rstReady", in_ready, 0);
        rst = 1'b0;

        $display("[TB] beats in IDLE are ignored");
        in_valid = 1'b1;
        pat_in = 2'b11;
        obs_in = 1'b1;
        exp_in = 1'b0;
        checkOutput("idleReady", in_ready, 0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("idleFailCnt", fail_cnt, 0);
        checkOutput("idleSig", signature, 0);

        $display("[TB] exhaustive passing run, num_pat=4");
        setBeat(0, 2'b00, 1'b1, 1'b1);
        setBeat(1, 2'b01, 1'b0, 1'b0);
        setBeat(2, 2'b10, 1'b0, 1'b0);
        setBeat(3, 2'b11, 1'b0, 1'b0);
        applyStimulus(4, 0);
        checkOutput("passRunPass", pass, 1);

        $display("[TB] restart from DONE with two failing beats");
        setBeat(2, 2'b10, 1'b1, 1'b0);
        setBeat(3, 2'b11, 1'b1, 1'b0);
        applyStimulus(4, 0);
        checkOutput("failRunCnt", fail_cnt, 2);
        checkOutput("failRunIdx", first_fail_idx, 2);

        $display("[TB] restart from DONE re-seeds after a failing run");
        setBeat(2, 2'b10, 1'b0, 1'b0);
        setBeat(3, 2'b11, 1'b0, 1'b0);
        applyStimulus(4, 0);

        $display("[TB] single beat run");
        setBeat(0, 2'b00, 1'b1, 1'b1);
        applyStimulus(1, 0);
        checkOutput("singleSigConst", signature, 16'hEFDE);

        $display("[TB] zero-length run");
        applyStimulus(0, 0);
        checkOutput("zeroPass", pass, 1);
        checkOutput("zeroSigConst", signature, 16'hFFFF);

        $display("[TB] run with 2-cycle gaps between beats");
        setBeat(0, 2'b00, 1'b1, 1'b1);
        setBeat(1, 2'b01, 1'b0, 1'b0);
        setBeat(2, 2'b10, 1'b0, 1'b0);
        setBeat(3, 2'b11, 1'b0, 1'b0);
        applyStimulus(4, 2);

        $display("[TB] reset in the middle of a run");
        start = 1'b1;
        num_pat = 8'd4;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        pat_in = 2'b01;
        obs_in = 1'b1;
        exp_in = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("midRunFailCnt", fail_cnt, 2);
        checkOutput("midRunBusy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstReady", in_ready, 0);
        checkOutput("midRstFailCnt", fail_cnt, 0);
        checkOutput("midRstFfValid", first_fail_valid, 0);
        checkOutput("midRstFfIdx", first_fail_idx, 0);
        checkOutput("midRstSig", signature, 0);

        $display("[TB] narrow counter, all beats mismatching");
        setBeat(0, 2'b00, 1'b1, 1'b0);
        setBeat(1, 2'b01, 1'b1, 1'b0);
        setBeat(2, 2'b10, 1'b1, 1'b0);
        pushExpected(3, 3);
        start2 = 1'b1;
        numPat2 = 2'd3;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            pat_in = bPat[i];
            obs_in = bObs[i];
            exp_in = bExp[i];
            checkOutput("narrowReady", ready2, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("narrowDone", done2, 1);
        checkOutput("narrowBusy", busy2, 0);
        e = sb.pop_front();
        checkOutput("narrowFailCnt", failCnt2, e.failCnt);
        checkOutput("narrowFfValid", ffValid2, e.ffValid);
        checkOutput("narrowFfIdx", ffIdx2, e.ffIdx);
        checkOutput("narrowPass", pass2, e.pass);
        checkOutput("narrowSig", sig2, e.sig);
        repeat (2) @(negedge clk);
        checkOutput("narrowFailCntHeld", failCnt2, 3);
        checkOutput("mainIdleDuringNarrow", fail_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
